// File: rtl/ex_div_if.sv
// ex_div_if: ID/EX-to-divider bundle.
// The master side is the ID/EX register plus controller (decoded instruction,
// operands, rd, flush). The slave side is the EX-stage divider, which returns
// the hold request, the busy flag and the register-write result.
interface ex_div_if #(
   parameter int XLEN = 32
);
   logic [31:0]     inst_i;
   logic [XLEN-1:0] op1_i;
   logic [XLEN-1:0] op2_i;
   logic [4:0]      reg_waddr_i;
   logic            reg_wen_i;
   logic            flush_i;
   logic            hold_req_o;
   logic            busy_o;
   logic [XLEN-1:0] result_o;
   logic            result_valid_o;
   logic [4:0]      reg_waddr_o;

   modport master (
      output inst_i, op1_i, op2_i, reg_waddr_i, reg_wen_i, flush_i,
      input  hold_req_o, busy_o, result_o, result_valid_o, reg_waddr_o
   );

   modport slave (
      input  inst_i, op1_i, op2_i, reg_waddr_i, reg_wen_i, flush_i,
      output hold_req_o, busy_o, result_o, result_valid_o, reg_waddr_o
   );
endinterface

// File: rtl/ex_div.sv
// ex_div: iterative RV32M divider (DIV/DIVU/REM/REMU) in the EX stage.
// Radix-2 restoring division on operand magnitudes, 32 BUSY cycles, with
// divide-by-zero and signed overflow resolved in a single cycle at start.
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, a divisor whose
// magnitude exceeds the dividend magnitude also completes in one cycle.
module ex_div #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input logic   clk_i,
   input logic   rst_n_i,
   ex_div_if.slave bus
);

   localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [4:0]      CNT_LAST = 5'(ITER - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state_q, state_nx;

   // magnitude of an operand: two's-complement absolute value for signed ops
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic           is_signed);
      return (is_signed && v[XLEN-1]) ? (~v + ONE) : v;
   endfunction

   // re-apply the latched sign to an unsigned quotient/remainder
   function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v,
                                                   input logic           neg);
      return neg ? (~v + ONE) : v;
   endfunction

   // decode
   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       is_div_op;
   logic       signed_op;
   logic       rem_op;
   logic       start;
   logic       unused_inst;

   assign opcode      = bus.inst_i[6:0];
   assign funct3      = bus.inst_i[14:12];
   assign funct7      = bus.inst_i[31:25];
   assign unused_inst = ^{bus.inst_i[24:15], bus.inst_i[11:7]};
   assign is_div_op   = (opcode == 7'b0110011) && (funct7 == 7'b0000001) &&
                        funct3[2] && bus.reg_wen_i;
   assign signed_op   = ~funct3[0];
   assign rem_op      = funct3[1];
   assign start       = (state_q == IDLE) && is_div_op && !bus.flush_i;

   // operand conditioning and single-cycle cases
   logic [XLEN-1:0] mag1, mag2;
   logic            div_zero, sgn_ovf, early, fast;
   logic [XLEN-1:0] fast_result;

   assign mag1     = magnitude(bus.op1_i, signed_op);
   assign mag2     = magnitude(bus.op2_i, signed_op);
   assign div_zero = (bus.op2_i == '0);
   assign sgn_ovf  = signed_op && (bus.op1_i == MIN_NEG) && (bus.op2_i == ALL_ONES);
`ifdef DIV_EARLY_OUT_EN
   assign early    = !div_zero && (mag2 > mag1);
`else
   assign early    = 1'b0;
`endif
   assign fast     = div_zero || sgn_ovf || early;

   // pick the one-cycle answer; early-out behaves like quotient 0, remainder op1
   always_comb begin
      fast_result = '0;
      if (div_zero)
         fast_result = rem_op ? bus.op1_i : ALL_ONES;
      else if (sgn_ovf)
         fast_result = rem_op ? '0 : MIN_NEG;
      else if (early)
         fast_result = rem_op ? bus.op1_i : '0;
   end

   // datapath registers
   logic [XLEN-1:0] rem_q, quot_q, dvs_q, result_q;
   logic [4:0]      cnt_q, rd_q;
   logic            rem_op_q, q_neg_q, r_neg_q;

   // one restoring step: shift {rem,quot} left, trial-subtract in XLEN+1 bits
   logic signed [XLEN:0] trial;
   logic [XLEN-1:0]      rem_nx, quot_nx, final_result;

   // restoring iteration and final sign correction
   always_comb begin
      trial   = $signed({rem_q, quot_q[XLEN-1]}) - $signed({1'b0, dvs_q});
      rem_nx  = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
      quot_nx = {quot_q[XLEN-2:0], 1'b0};
      if (!trial[XLEN]) begin
         rem_nx  = trial[XLEN-1:0];
         quot_nx = {quot_q[XLEN-2:0], 1'b1};
      end
      final_result = rem_op_q ? apply_sign(rem_nx, r_neg_q)
                              : apply_sign(quot_nx, q_neg_q);
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         state_q <= IDLE;
      else
         state_q <= state_nx;
   end

   // FSM next-state logic; flush returns to IDLE from BUSY, DONE always ends
   always_comb begin
      state_nx = state_q;
      unique case (state_q)
         IDLE: if (start) state_nx = fast ? DONE : BUSY;
         BUSY: begin
            if (bus.flush_i)
               state_nx = IDLE;
            else if (cnt_q == CNT_LAST)
               state_nx = DONE;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs; hold is combinational from start to stall the next instruction
   always_comb begin
      bus.hold_req_o     = start || ((state_q == BUSY) && !bus.flush_i);
      bus.busy_o         = (state_q == BUSY);
      bus.result_valid_o = (state_q == DONE) && !bus.flush_i;
   end

   // capture at start, iterate while BUSY, register the result on entry to DONE
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rem_q    <= '0;
         quot_q   <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         rd_q     <= '0;
         rem_op_q <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
      end else if (start) begin
         rd_q     <= bus.reg_waddr_i;
         rem_op_q <= rem_op;
         q_neg_q  <= signed_op && (bus.op1_i[XLEN-1] ^ bus.op2_i[XLEN-1]);
         r_neg_q  <= signed_op && bus.op1_i[XLEN-1];
         dvs_q    <= mag2;
         quot_q   <= mag1;
         rem_q    <= '0;
         cnt_q    <= '0;
         if (fast)
            result_q <= fast_result;
      end else if ((state_q == BUSY) && !bus.flush_i) begin
         rem_q  <= rem_nx;
         quot_q <= quot_nx;
         cnt_q  <= cnt_q + 5'd1;
         if (cnt_q == CNT_LAST)
            result_q <= final_result;
      end
   end

   assign bus.result_o    = result_q;
   assign bus.reg_waddr_o = rd_q;

endmodule
